// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-word reads to memory and
// hands each fetched instruction with its PC to decode over valid/ready.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000,
    parameter int                    DEPTH      = 1048576
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] insn,
    output logic [ADDR_WIDTH-1:0] insn_pc,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    output logic                  fault
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        FAULT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        START_ADDR + ADDR_WIDTH'(DEPTH) - ADDR_WIDTH'(4);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic                    capture;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= START_ADDR) && (addr <= LAST_ADDR);
    endfunction

    // Every way into ISSUE goes through the range check; a bad PC parks in FAULT.
    function automatic state_t start_state(input logic go,
                                           input logic [ADDR_WIDTH-1:0] addr);
        if (!go)
            return IDLE;
        return in_range(addr) ? ISSUE : FAULT;
    endfunction

    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);

    always_comb begin
        next_state = state;
        next_pc    = pc;
        capture    = 1'b0;
        if (redirect_valid) begin
            next_pc    = redirect_target;
            next_state = start_state(run, redirect_target);
        end else begin
            case (state)
                IDLE:    if (run) next_state = start_state(1'b1, pc);
                ISSUE:   if (!mem_busy) next_state = WAIT;
                WAIT: begin
                    capture    = 1'b1;
                    next_pc    = pc + ADDR_WIDTH'(4);
                    next_state = HOLD;
                end
                HOLD:    if (insn_ready) next_state = start_state(run, pc);
                FAULT:   next_state = FAULT;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= START_ADDR;
            insn    <= '0;
            insn_pc <= '0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (capture) begin
                insn    <= mem_data_out;
                insn_pc <= pc;
            end
        end
    end

    // Outputs are pure decodes of registered state so no input reaches an output.
    assign mem_address     = pc;
    assign mem_access_size = 2'b00;
    assign mem_rw          = 1'b1;
    assign mem_enable      = (state == ISSUE);
    assign insn_valid      = (state == HOLD);
    assign fault           = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a simple one-cycle-latency memory model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data_out = 32'h0;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic        fault;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .run             (run),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_address     (mem_address),
        .mem_access_size (mem_access_size),
        .mem_rw          (mem_rw),
        .mem_enable      (mem_enable),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .insn            (insn),
        .insn_pc         (insn_pc),
        .insn_valid      (insn_valid),
        .insn_ready      (insn_ready),
        .fault           (fault)
    );

    always #5 clock = ~clock;

    // Preloaded words at the first two addresses; elsewhere address + 0x10000000.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h80020000: return 32'h11111111;
            32'h80020004: return 32'h22222222;
            default:      return addr + 32'h10000000;
        endcase
    endfunction

    always @(posedge clock) begin
        if (mem_enable && !mem_busy)
            mem_data_out <= mem_word(mem_address);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic bsy,
                                 input logic rv, input logic [31:0] rpc);
        run            = r;
        insn_ready     = rdy;
        mem_busy       = bsy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic checkHold(input string tag, input logic [31:0] exp_insn,
                             input logic [31:0] exp_pc);
        checkOutput({tag, "_valid"}, 32'(insn_valid), 32'd1);
        checkOutput({tag, "_insn"}, insn, exp_insn);
        checkOutput({tag, "_pc"}, insn_pc, exp_pc);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(2);
        checkOutput("rst_valid", 32'(insn_valid), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_en", 32'(mem_enable), 32'd0);
        checkOutput("rst_addr", mem_address, 32'h80020000);
        checkOutput("rst_rw", 32'(mem_rw), 32'd1);
        checkOutput("rst_size", 32'(mem_access_size), 32'd0);
        checkOutput("rst_insn", insn, 32'h0);
        checkOutput("rst_insn_pc", insn_pc, 32'h0);
        reset = 1'b0;

        // Baseline: valid two edges after run, next instruction three later.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("b_issue_en", 32'(mem_enable), 32'd1);
        checkOutput("b_issue_addr", mem_address, 32'h80020000);
        tick(1);
        checkOutput("b_wait_en", 32'(mem_enable), 32'd0);
        checkOutput("b_wait_valid", 32'(insn_valid), 32'd0);
        tick(1);
        checkHold("b_first", 32'h11111111, 32'h80020000);
        tick(1);
        checkOutput("b_issue2_addr", mem_address, 32'h80020004);
        checkOutput("b_issue2_valid", 32'(insn_valid), 32'd0);
        tick(2);
        checkHold("b_second", 32'h22222222, 32'h80020004);

        // Decode stalls for five cycles.
        insn_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkHold("stall", 32'h22222222, 32'h80020004);
            checkOutput("stall_en", 32'(mem_enable), 32'd0);
        end
        insn_ready = 1'b1;
        tick(1);
        checkOutput("resume_en", 32'(mem_enable), 32'd1);
        checkOutput("resume_addr", mem_address, 32'h80020008);
        tick(2);
        checkHold("resume", 32'h90020008, 32'h80020008);

        // Memory busy for three ISSUE cycles.
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("busy_en", 32'(mem_enable), 32'd1);
            checkOutput("busy_addr", mem_address, 32'h8002000C);
            checkOutput("busy_valid", 32'(insn_valid), 32'd0);
        end
        mem_busy = 1'b0;
        tick(1);
        checkOutput("busy_wait_en", 32'(mem_enable), 32'd0);
        tick(1);
        checkHold("busy", 32'h9002000C, 32'h8002000C);

        // Redirect while WAIT: in-flight word dropped.
        tick(2);
        checkOutput("rw_wait_en", 32'(mem_enable), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h80020103);
        tick(1);
        redirect_valid = 1'b0;
        checkOutput("rw_en", 32'(mem_enable), 32'd1);
        checkOutput("rw_addr", mem_address, 32'h80020100);
        checkOutput("rw_valid", 32'(insn_valid), 32'd0);
        checkOutput("rw_insn_kept", insn, 32'h9002000C);
        tick(2);
        checkHold("rw", 32'h90020100, 32'h80020100);

        // Out-of-range redirect faults; drops the held instruction.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h80000000);
        tick(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("flt_fault", 32'(fault), 32'd1);
            checkOutput("flt_en", 32'(mem_enable), 32'd0);
            checkOutput("flt_valid", 32'(insn_valid), 32'd0);
            tick(1);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h80020000);
        tick(1);
        redirect_valid = 1'b0;
        checkOutput("clr_fault", 32'(fault), 32'd0);
        checkOutput("clr_en", 32'(mem_enable), 32'd1);
        checkOutput("clr_addr", mem_address, 32'h80020000);
        tick(2);
        checkHold("clr", 32'h11111111, 32'h80020000);

        // Last legal word, then falling off the end faults.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h8011FFFC);
        tick(1);
        redirect_valid = 1'b0;
        checkOutput("end_addr", mem_address, 32'h8011FFFC);
        checkOutput("end_en", 32'(mem_enable), 32'd1);
        tick(2);
        checkHold("end", 32'h9011FFFC, 32'h8011FFFC);
        tick(1);
        checkOutput("end_fault", 32'(fault), 32'd1);
        checkOutput("end_fault_en", 32'(mem_enable), 32'd0);
        checkOutput("end_fault_addr", mem_address, 32'h80120000);

        // Redirect with run low goes idle without fetching.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h80020004);
        tick(1);
        redirect_valid = 1'b0;
        checkOutput("idle_fault", 32'(fault), 32'd0);
        tick(1);
        checkOutput("idle_en", 32'(mem_enable), 32'd0);
        checkOutput("idle_addr", mem_address, 32'h80020004);

        // Reset during WAIT.
        run = 1'b1;
        tick(2);
        checkOutput("rw2_wait_en", 32'(mem_enable), 32'd0);
        reset = 1'b1;
        tick(1);
        checkOutput("rst2_valid", 32'(insn_valid), 32'd0);
        checkOutput("rst2_en", 32'(mem_enable), 32'd0);
        checkOutput("rst2_addr", mem_address, 32'h80020000);
        checkOutput("rst2_insn", insn, 32'h0);
        checkOutput("rst2_insn_pc", insn_pc, 32'h0);
        checkOutput("rst2_fault", 32'(fault), 32'd0);
        run = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
        checkOutput("rst2_after_valid", 32'(insn_valid), 32'd0);
        checkOutput("rst2_after_en", 32'(mem_enable), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly upstream of the byte-addressable `memory` block and downstream-feeding the decode stage. Maintains the program counter, issues single-word reads (`access_size` 2'b00) to memory, captures the returned word, and presents it with its PC to decode over a valid/ready handshake. Supports PC redirect (branch/jump) with discard of in-flight reads, and raises a sticky fault on out-of-range fetch addresses.

## Interface
Parameters:
- `START_ADDR`, 32'h80020000, base address of memory; reset PC.
- `DEPTH`, 1048576, memory size in bytes; legal PCs are `START_ADDR` to `START_ADDR+DEPTH-4`.
- `ADDR_WIDTH`, 32, address/PC width.
- `DATA_WIDTH`, 32, instruction width.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = fetching permitted; 0 = finish current instruction handoff, then idle.
- `redirect_valid`  in  1  load new PC this cycle.
- `redirect_pc`  in  32  target PC; bits [1:0] are forced to 0.
- `mem_address`  out  32  read address to memory (= `pc`).
- `mem_access_size`  out  2  constant 2'b00 (1 word).
- `mem_rw`  out  1  constant 1 (read).
- `mem_enable`  out  1  read request strobe.
- `mem_busy`  in  1  memory busy; request is held while high.
- `mem_data_out`  in  32  read data, valid the cycle after the accepting edge.
- `insn`  out  32  captured instruction.
- `insn_pc`  out  32  address `insn` was fetched from.
- `insn_valid`  out  1  `insn`/`insn_pc` valid for decode.
- `insn_ready`  in  1  decode accepts when `insn_valid & insn_ready` at an edge.
- `fault`  out  1  sticky: attempted fetch outside legal range.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD, FAULT.
- Reset: state IDLE, `pc`=`START_ADDR`, `insn`=0, `insn_pc`=0, `insn_valid`=0, `fault`=0; `mem_enable`=0, `mem_address`=`START_ADDR`, `mem_rw`=1, `mem_access_size`=2'b00.
- IDLE: `run`=1 -> ISSUE (after range check, below).
- Range check on entry to ISSUE: `pc < START_ADDR` or `pc > START_ADDR+DEPTH-4` -> FAULT instead, `fault`<=1.
- ISSUE: `mem_enable`=1, `mem_address`=`pc`. Edge with `mem_busy`=0 -> WAIT; `mem_busy`=1 -> stay ISSUE, outputs unchanged.
- WAIT: `mem_enable`=0. Edge: `insn`<=`mem_data_out` (unmodified), `insn_pc`<=`pc`, `insn_valid`<=1, `pc`<=`pc+4` (mod 2^32), -> HOLD.
- HOLD: `insn_valid`=1, `insn`/`insn_pc` stable. Edge with `insn_ready`=1: `insn_valid`<=0, -> ISSUE if `run` (with range check) else IDLE.
- FAULT: `mem_enable`=0, `insn_valid`=0; exits only on `redirect_valid` or `reset`.
- Redirect (any state, highest priority after reset): `pc`<={`redirect_pc`[31:2],2'b00}, `insn_valid`<=0 (any unconsumed instruction dropped, even if `insn_ready`=1 that edge), `fault`<=0, in-flight WAIT data discarded; next state ISSUE (range-checked) if `run` else IDLE.
- `run` falling in ISSUE/WAIT: current fetch completes to HOLD; stop takes effect after handoff.
- `mem_enable` high only in ISSUE; never two requests outstanding.

## Timing
- `mem_*` outputs and `insn_valid`/`fault` decode from registered state; no combinational path from any input to any output.
- Best-case latency: `run` sampled at edge 0 -> ISSUE; edge 1 memory accepts; edge 2 `insn_valid`=1; 3 cycles per instruction with `insn_ready` tied high.
- Each `mem_busy` cycle in ISSUE adds one cycle.
- Redirect at edge N: `mem_enable`=1 with new address during cycle N+1.
- Reset mid-fetch: returns to reset values at that edge; stale `mem_data_out` ignored.
- PC wrap at 32'hFFFFFFFC -> 0 is arithmetic only; range check then faults.

## Test plan
- Reset, `run`=1, memory preloaded 0x11111111 at 0x80020000, 0x22222222 at 0x80020004, `insn_ready`=1 -> `insn` 0x11111111/`insn_pc` 0x80020000 valid 2 cycles after run, then 0x22222222/0x80020004 three cycles later.
- `insn_ready`=0 for 5 cycles in HOLD -> `insn`, `insn_pc`, `insn_valid` stable; no `mem_enable` pulse; resumes on ready.
- `mem_busy`=1 for 3 cycles during ISSUE -> `mem_enable`/`mem_address` held; instruction appears 3 cycles later than baseline.
- `redirect_valid` with `redirect_pc`=0x80020103 during WAIT -> old data discarded, next `mem_address`=0x80020100, next `insn_pc`=0x80020100.
- Redirect to 0x80000000 -> `fault`=1, `mem_enable` stays 0; redirect to 0x80020000 clears `fault` and fetch resumes; `pc` reaching 0x80120000 also faults.
- Assert `reset` while in WAIT -> all outputs at reset values next cycle; no `insn_valid` pulse.
